branch_outcome_queue: RTL and testbench
=======================================

# branch_outcome_queue

Buffers resolved branch outcomes from two execute-stage resolution ports and replays them one per cycle into the two-bit saturating predictor as its `taken`/`transition` update pair. It sits directly upstream of the predictor. It decouples bursty dual resolution from the predictor's single-update-per-cycle input and preserves program order, with port A older than port B in the same cycle.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries; power of two, ≥ 2.
- `CW`, `$clog2(DEPTH)+1`: width of `count` (derived, do not override).

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; queue cleared while `reset`==0.
- `pushA`  in  1  port A has a resolved branch this cycle (older).
- `takenA`  in  1  outcome for port A (1 = taken).
- `pushB`  in  1  port B has a resolved branch this cycle (younger).
- `takenB`  in  1  outcome for port B.
- `stall`  in  1  predictor cannot accept an update this cycle.
- `transition`  out  1  registered; 1 = predictor must apply `taken` this cycle.
- `taken`  out  1  registered outcome being replayed; 0 when `transition`==0.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `empty`  out  1  `count`==0 (combinational from `count`).
- `full`  out  1  `count`==DEPTH (combinational from `count`).
- `dropA`  out  1  registered one-cycle pulse: port A push was discarded last edge.
- `dropB`  out  1  registered one-cycle pulse: port B push was discarded last edge.

## Operation
- Storage: circular buffer of DEPTH 1-bit entries, with head/tail pointers of `$clog2(DEPTH)` bits that wrap modulo DEPTH, plus the `count` register.
- Pop decision: `pop` = (`count`≠0) & ~`stall`, evaluated on pre-edge state.
  - On edge with `pop`: `transition`<=1, `taken`<=entry[head], head advances.
  - Otherwise: `transition`<=0, `taken`<=0.
- Free slots for this edge: `free` = DEPTH − `count` + `pop`. A pop frees its slot for same-edge pushes.
- Push acceptance, in order A then B:
  - A is accepted if `pushA` & `free`≥1.
  - B is accepted if `pushB` & `free` ≥ 1 + (A accepted).
  - Accepted entries are written at tail, then tail+1, preserving A-before-B order.
  - If only B pushes, it takes the tail slot.
- Drop policy: a rejected push is lost. `dropA`/`dropB`<=1 for exactly that edge, else 0.
  - No backpressure is given to execute; software-visible accuracy loss only.
- Count update: `count` <= `count` + accA + accB − `pop`. Never exceeds DEPTH and never underflows.
- Throughput: one entry replayed per unstalled cycle, and up to two accepted per cycle.
- `stall` only gates pop. It never blocks pushes beyond the capacity limits above.
- Reset (asynchronous, `reset`==0, mid-operation included):
  - head=tail=0, `count`=0.
  - `transition`=0, `taken`=0, `dropA`=`dropB`=0.
  - Hence `empty`=1, `full`=0.
  - All in-flight entries are discarded.
  - Storage contents need not be cleared.
- No state machine beyond the pointer/count datapath; the behaviour is fully defined by the rules above.

## Timing
- Latency: an entry pushed into an empty queue at posedge k appears on `transition`/`taken` after posedge k+1, given `stall`=0 before edge k+1.
- Push and pop on the same edge: the pop reads the pre-edge head, so it never returns an entry written on that same edge.
- `stall` sampled high at edge k: `transition`=0 after edge k. The head entry is retained and replayed on the first unstalled edge.
- `count`, `empty`, `full` reflect post-edge state. `dropA`/`dropB` are valid for the cycle following the rejecting edge.
- Pointer wrap: after index DEPTH−1, the pointer wraps to 0 with no bubble.
- Reset deassertion: first functional edge is the first posedge with `reset`==1.

## Test plan
- Reset/idle: hold `reset`=0 two cycles, then release with no pushes. Required: `transition`=0, `taken`=0, `count`=0, `empty`=1, `full`=0 throughout.
- Single latency: push A (`takenA`=1) at edge k. Required: `count`=1 after k; `transition`=1, `taken`=1 after k+1; `count`=0 and `empty`=1 after k+1.
- Dual ordering: push A=1 and B=0 on the same edge, with `stall`=0. Required: replays `taken`=1 then `taken`=0 on consecutive cycles.
- Overflow/drop, DEPTH=4, `stall`=1:
  - Two dual pushes fill the queue (`full`=1).
  - A third dual push gives `dropA`=`dropB`=1 for one cycle, and `count` stays 4.
  - Release `stall`: the four original outcomes drain in order.
- Full with simultaneous pop: `count`=4, `stall`=0, dual push. Required: A accepted, B dropped (`dropB`=1, `dropA`=0), `count` stays 4. Then drain to confirm wrap-around order.
- Reset mid-operation: with `count`=3 and `transition`=1, pull `reset` low between edges. Required: outputs clear immediately (asynchronous). After release, the next push has normal two-edge latency, with no stale entries replayed.

Source files
------------

// File: rtl/branch_outcome_queue.sv
// branch_outcome_queue: buffers dual-port branch outcomes and replays one per cycle to the predictor
// Ports: clock/reset (async active-low); pushA/takenA (older) and pushB/takenB (younger) resolution inputs;
//        stall gates replay; transition/taken registered update pair; count/empty/full occupancy;
//        dropA/dropB registered one-cycle pulses for discarded pushes.
module branch_outcome_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pushA,
    input  logic          takenA,
    input  logic          pushB,
    input  logic          takenB,
    input  logic          stall,
    output logic          transition,
    output logic          taken,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          dropA,
    output logic          dropB
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    head, tail;
    logic [CW-1:0]    free;
    logic             pop, acc_a, acc_b;
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    // a same-edge pop frees its slot for incoming pushes
    always_comb begin
        pop   = !empty && !stall;
        free  = CW'(DEPTH) - count + CW'(pop);
        acc_a = pushA && free >= CW'(1);
        acc_b = pushB && free >= (acc_a ? CW'(2) : CW'(1));
    end
    always_ff @(posedge clock) begin
        if (acc_a) mem[tail] <= takenA;
        if (acc_b) mem[acc_a ? tail + AW'(1) : tail] <= takenB;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            transition <= 1'b0;
            taken      <= 1'b0;
            dropA      <= 1'b0;
            dropB      <= 1'b0;
        end else begin
            head       <= head + AW'(pop);
            tail       <= tail + AW'(acc_a) + AW'(acc_b);
            count      <= count + CW'(acc_a) + CW'(acc_b) - CW'(pop);
            transition <= pop;
            taken      <= pop && mem[head];
            dropA      <= pushA && !acc_a;
            dropB      <= pushB && !acc_b;
        end
    end
endmodule

// File: tb/tb_branch_outcome_queue.sv
// tb_branch_outcome_queue: randomized and directed checks of branch_outcome_queue against a queue-based model
module tb_branch_outcome_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          pushA = 1'b0, takenA = 1'b0, pushB = 1'b0, takenB = 1'b0, stall = 1'b0;
    logic          transition, taken, empty, full, dropA, dropB;
    logic [CW-1:0] count;
    int            checks = 0;
    int            failures = 0;
    bit            q[$];
    bit            e_trans = 0, e_taken = 0, e_drop_a = 0, e_drop_b = 0;

    branch_outcome_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .pushA(pushA), .takenA(takenA), .pushB(pushB),
        .takenB(takenB), .stall(stall), .transition(transition), .taken(taken),
        .count(count), .empty(empty), .full(full), .dropA(dropA), .dropB(dropB)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".transition"}, 32'(transition), 32'(e_trans));
        chk({tag, ".taken"}, 32'(taken), 32'(e_taken));
        chk({tag, ".count"}, 32'(count), q.size());
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".dropA"}, 32'(dropA), 32'(e_drop_a));
        chk({tag, ".dropB"}, 32'(dropB), 32'(e_drop_b));
    endtask

    function automatic void model_clear();
        q.delete();
        e_trans = 0; e_taken = 0; e_drop_a = 0; e_drop_b = 0;
    endfunction

    // one edge of the model: replay oldest unless stalled, then accept A then B into remaining room
    function automatic void model_edge(bit pa, bit ta, bit pb, bit tb, bit st);
        bit pop = q.size() != 0 && !st;
        int room;
        bit acc_a, acc_b;
        e_trans = pop;
        e_taken = 0;
        if (pop) e_taken = q.pop_front();
        room  = DEPTH - q.size();
        acc_a = pa && room >= 1;
        if (acc_a) q.push_back(ta);
        room  = DEPTH - q.size();
        acc_b = pb && room >= 1;
        if (acc_b) q.push_back(tb);
        e_drop_a = pa && !acc_a;
        e_drop_b = pb && !acc_b;
    endfunction

    task automatic step(input string tag, input bit pa, input bit ta, input bit pb, input bit tb, input bit st);
        pushA = pa; takenA = ta; pushB = pb; takenB = tb; stall = st;
        @(posedge clock);
        model_edge(pa, ta, pb, tb, st);
        #1;
        chk_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            chk_all("reset_hold");
        end
        @(negedge clock);
        reset = 1'b1;
        idle("idle", 3);
        step("lat_push", 1, 1, 0, 0, 0);
        idle("lat_pop", 2);
        step("dual_push", 1, 1, 1, 0, 0);
        idle("dual_drain", 3);
        step("ovf_fill1", 1, 1, 1, 0, 1);
        step("ovf_fill2", 1, 0, 1, 1, 1);
        step("ovf_drop", 1, 1, 1, 1, 1);
        step("ovf_hold", 0, 0, 0, 0, 1);
        idle("ovf_drain", 5);
        step("fp_fill1", 1, 0, 1, 1, 1);
        step("fp_fill2", 1, 1, 1, 0, 1);
        step("fp_dual", 1, 0, 1, 1, 0);
        idle("fp_drain", 6);
        step("mr_fill1", 1, 1, 1, 0, 1);
        step("mr_fill2", 1, 1, 0, 0, 1);
        step("mr_popush", 1, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk_all("mr_async");
        @(posedge clock);
        #1;
        chk_all("mr_hold");
        @(negedge clock);
        reset = 1'b1;
        step("mr_push", 1, 1, 0, 0, 0);
        idle("mr_after", 3);
        for (int i = 0; i < 3000; i++) begin
            bit st = $urandom_range(0, 99) < 35;
            step("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), st);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset = 1'b0;
                #1;
                model_clear();
                chk_all("rand_arst");
                @(negedge clock);
                reset = 1'b1;
            end
        end
        idle("final_drain", 6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
